// File: rtl/sprite_draw_scheduler.sv
// Frame draw sequencer: erases previous sprite rectangles and draws new ones
// one pixel at a time into the VGA plot port, with clipping and backpressure.
module sprite_draw_scheduler #(
    parameter int NUM_OBJ   = 6,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int SIZE_W    = 5,
    parameter int COL_W     = 3,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int BG_COLOUR = 0,
    parameter int ERASE_EN  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frame_start,
    input  logic [NUM_OBJ*X_W-1:0]    obj_x,
    input  logic [NUM_OBJ*Y_W-1:0]    obj_y,
    input  logic [NUM_OBJ*SIZE_W-1:0] obj_w,
    input  logic [NUM_OBJ*SIZE_W-1:0] obj_h,
    input  logic [NUM_OBJ*COL_W-1:0]  obj_c,
    input  logic [NUM_OBJ-1:0]        obj_valid,
    input  logic                      plot_ready,
    output logic                      plot,
    output logic [X_W-1:0]            vga_x,
    output logic [Y_W-1:0]            vga_y,
    output logic [COL_W-1:0]          vga_colour,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        PIX,
        DONE
    } state_t;

    state_t              state, state_n;
    logic                erase, erase_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [SIZE_W-1:0]   cx, cx_n;
    logic [SIZE_W-1:0]   cy, cy_n;
    logic                snap;
    logic                commit;
    logic                adv;

    logic [NUM_OBJ*X_W-1:0]    cur_x, prev_x;
    logic [NUM_OBJ*Y_W-1:0]    cur_y, prev_y;
    logic [NUM_OBJ*SIZE_W-1:0] cur_w, prev_w;
    logic [NUM_OBJ*SIZE_W-1:0] cur_h, prev_h;
    logic [NUM_OBJ*COL_W-1:0]  cur_c;
    logic [NUM_OBJ-1:0]        cur_v, prev_v;

    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [SIZE_W-1:0] sel_w;
    logic [SIZE_W-1:0] sel_h;
    logic [COL_W-1:0]  sel_c;
    logic              sel_v;
    logic [X_W:0]      px;
    logic [Y_W:0]      py;
    logic              on_screen;
    logic              last_x;
    logic              last_y;
    logic              last_idx;

    // Pick the rectangle for the current index: old frame when erasing.
    always_comb begin
        sel_x = cur_x[int'(idx)*X_W +: X_W];
        sel_y = cur_y[int'(idx)*Y_W +: Y_W];
        sel_w = cur_w[int'(idx)*SIZE_W +: SIZE_W];
        sel_h = cur_h[int'(idx)*SIZE_W +: SIZE_W];
        sel_v = cur_v[idx];
        sel_c = cur_c[int'(idx)*COL_W +: COL_W];
        if (erase) begin
            sel_x = prev_x[int'(idx)*X_W +: X_W];
            sel_y = prev_y[int'(idx)*Y_W +: Y_W];
            sel_w = prev_w[int'(idx)*SIZE_W +: SIZE_W];
            sel_h = prev_h[int'(idx)*SIZE_W +: SIZE_W];
            sel_v = prev_v[idx];
            sel_c = COL_W'(BG_COLOUR);
        end
    end

    // Pixel address is one bit wider so off-screen sprites never wrap back.
    always_comb begin
        px        = {1'b0, sel_x} + (X_W+1)'(cx);
        py        = {1'b0, sel_y} + (Y_W+1)'(cy);
        on_screen = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));
        last_x    = (cx == sel_w - 1'b1);
        last_y    = (cy == sel_h - 1'b1);
        last_idx  = (idx == IDX_W'(NUM_OBJ - 1));
    end

    // Next-state logic: object walk, raster walk and phase change.
    always_comb begin
        state_n = state;
        erase_n = erase;
        idx_n   = idx;
        cx_n    = cx;
        cy_n    = cy;
        snap    = 1'b0;
        commit  = 1'b0;
        adv     = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    state_n = SEL;
                    erase_n = (ERASE_EN != 0);
                    idx_n   = '0;
                    snap    = 1'b1;
                end
            end
            SEL: begin
                if (sel_v && sel_w != '0 && sel_h != '0) begin
                    cx_n    = '0;
                    cy_n    = '0;
                    state_n = PIX;
                end else begin
                    adv = 1'b1;
                end
            end
            PIX: begin
                if (!on_screen || plot_ready) begin
                    if (last_x) begin
                        cx_n = '0;
                        if (last_y) begin
                            adv = 1'b1;
                        end else begin
                            cy_n = cy + 1'b1;
                        end
                    end else begin
                        cx_n = cx + 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                commit  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (adv) begin
            if (last_idx) begin
                if (erase) begin
                    erase_n = 1'b0;
                    idx_n   = '0;
                    state_n = SEL;
                end else begin
                    state_n = DONE;
                end
            end else begin
                idx_n   = idx + 1'b1;
                state_n = SEL;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            erase <= 1'b0;
            idx   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_n;
            erase <= erase_n;
            idx   <= idx_n;
            cx    <= cx_n;
            cy    <= cy_n;
        end
    end

    // Frame shadows: snapshot at start, promote to previous at end of pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x  <= '0;
            cur_y  <= '0;
            cur_w  <= '0;
            cur_h  <= '0;
            cur_c  <= '0;
            cur_v  <= '0;
            prev_x <= '0;
            prev_y <= '0;
            prev_w <= '0;
            prev_h <= '0;
            prev_v <= '0;
        end else if (snap) begin
            cur_x <= obj_x;
            cur_y <= obj_y;
            cur_w <= obj_w;
            cur_h <= obj_h;
            cur_c <= obj_c;
            cur_v <= obj_valid;
        end else if (commit) begin
            prev_x <= cur_x;
            prev_y <= cur_y;
            prev_w <= cur_w;
            prev_h <= cur_h;
            prev_v <= cur_v;
        end
    end

    // Plot port and status outputs.
    always_comb begin
        plot       = (state == PIX) && on_screen;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (plot) begin
            vga_x      = px[X_W-1:0];
            vga_y      = py[Y_W-1:0];
            vga_colour = sel_c;
        end
        busy       = (state == SEL) || (state == PIX);
        frame_done = (state == DONE);
    end

endmodule
